mailbox_reader: RTL

- Read-side agent for the 8-entry mailbox FIFO.
- Drains bytes from the mailbox's read port with a latency-aware prefetch buffer, then parses length-prefixed messages.
- Frame format: byte 0 = payload length N, followed by N payload bytes.
- Emits payload as a valid/ready byte stream with start/end markers, toward the consumer side of the testbench.

---
 rtl/mailbox_pkg.sv | 10 +
 rtl/mb_prefetch_buf.sv | 56 +++++
 rtl/mailbox_reader.sv | 132 +++++++++++++
 3 files changed

// File: rtl/mailbox_pkg.sv
// Shared definitions for the mailbox FIFO and its read-side agent.
package mailbox_pkg;
    localparam int DATA_W   = 8;
    localparam int MB_DEPTH = 8;

    typedef enum logic {
        HDR     = 1'b0,
        PAYLOAD = 1'b1
    } rd_state_e;
endpackage

// File: rtl/mb_prefetch_buf.sv
// Small circular FIFO that absorbs mailbox read data across the one-cycle read latency.
module mb_prefetch_buf #(
    parameter int DATA_W    = 8,
    parameter int BUF_DEPTH = 2,
    parameter int CNT_BW    = $clog2(BUF_DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] pop_data,
    output logic [CNT_BW-1:0] count,
    output logic              empty
);
    localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;

    logic [DATA_W-1:0] mem [BUF_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(BUF_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign empty    = (count == '0);
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({push, do_pop})
                2'b10:   count <= count + CNT_BW'(1);
                2'b01:   count <= count - CNT_BW'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/mailbox_reader.sv
// Read-side mailbox agent: prefetches bytes, parses length-prefixed frames and
// streams the payload out as valid/ready beats with start/end markers.
module mailbox_reader #(
    parameter int DATA_W    = mailbox_pkg::DATA_W,
    parameter int BUF_DEPTH = 2,
    parameter int CNT_W     = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    output logic              mb_read_en,
    input  logic              mb_empty,
    input  logic [DATA_W-1:0] mb_data_out,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              m_sop,
    output logic              m_eop,
    output logic              busy,
    output logic [CNT_W-1:0]  msg_count
);
    import mailbox_pkg::*;

    localparam int OCC_W = $clog2(BUF_DEPTH + 1);

    rd_state_e         state;
    rd_state_e         state_nxt;
    logic [OCC_W-1:0]  buf_count;
    logic [OCC_W:0]    pending;
    logic [DATA_W-1:0] buf_data;
    logic [DATA_W-1:0] rem;
    logic              buf_empty;
    logic              inflight;
    logic              pop;
    logic              first;
    logic              hdr_pop;
    logic              zero_hdr;
    logic              beat_load;
    logic [1:0]        done_inc;

    // Reads are only issued when the buffer can hold everything already requested.
    assign pending    = {1'b0, buf_count} + {{OCC_W{1'b0}}, inflight};
    assign mb_read_en = rst && enable && !mb_empty && (pending < (OCC_W + 1)'(BUF_DEPTH));

    assign hdr_pop   = (state == HDR) && pop;
    assign zero_hdr  = hdr_pop && (buf_data == '0);
    assign beat_load = (state == PAYLOAD) && pop;
    assign done_inc  = 2'(m_valid && m_ready && m_eop) + 2'(zero_hdr);

    mb_prefetch_buf #(
        .DATA_W    (DATA_W),
        .BUF_DEPTH (BUF_DEPTH),
        .CNT_BW    (OCC_W)
    ) u_buf (
        .clk       (clk),
        .rst       (rst),
        .push      (inflight),
        .push_data (mb_data_out),
        .pop       (pop),
        .pop_data  (buf_data),
        .count     (buf_count),
        .empty     (buf_empty)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= HDR;
            inflight <= 1'b0;
        end else begin
            state    <= state_nxt;
            inflight <= mb_read_en;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            HDR:     if (pop && buf_data != '0) state_nxt = PAYLOAD;
            PAYLOAD: if (pop && rem == DATA_W'(1)) state_nxt = HDR;
            default: state_nxt = HDR;
        endcase
    end

    // Headers drain regardless of m_ready; payload waits for a free output slot.
    always_comb begin
        pop  = 1'b0;
        busy = 1'b0;
        case (state)
            HDR: begin
                pop = !buf_empty;
            end
            PAYLOAD: begin
                busy = 1'b1;
                pop  = !buf_empty && (!m_valid || m_ready);
            end
            default: begin
                pop  = 1'b0;
                busy = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rem       <= '0;
            first     <= 1'b0;
            m_valid   <= 1'b0;
            m_data    <= '0;
            m_sop     <= 1'b0;
            m_eop     <= 1'b0;
            msg_count <= '0;
        end else begin
            msg_count <= msg_count + CNT_W'(done_inc);
            if (hdr_pop && !zero_hdr) begin
                rem   <= buf_data;
                first <= 1'b1;
            end
            if (beat_load) begin
                rem     <= rem - DATA_W'(1);
                first   <= 1'b0;
                m_valid <= 1'b1;
                m_data  <= buf_data;
                m_sop   <= first;
                m_eop   <= (rem == DATA_W'(1));
            end else if (m_ready) begin
                m_valid <= 1'b0;
                m_sop   <= 1'b0;
                m_eop   <= 1'b0;
            end
        end
    end
endmodule
